duv_mem_arb: RTL and testbench
==============================

# duv_mem_arb

Round-robin arbiter that shares the single-port 1024x32 DUV memory (`duv.mem`) between several requesters: testbench drivers, DPI/python-side back-door agents, and future RTL masters. Sits inside the DUV beside the memory. It selects one request per cycle, forwards it to the memory port and routes read data back to the winner. An optional bounded lock gives a requester back-to-back ownership for bursts.

## Interface
- `REQUESTERS`, 4: number of requesters, 2..8.
- `ADDR_W`, 10: address width; memory depth is 2**ADDR_W.
- `DATA_W`, 32: data width.
- `LOCK_MAX`, 16: maximum consecutive locked cycles, 1..255.

Ports:
- `duv_mem_arb_clk_ip`, in, 1: clock; all state on rising edge.
- `duv_mem_arb_rst_ip`, in, 1: synchronous, active-high reset.
- `duv_mem_arb_req_ip`, in, REQUESTERS: request per requester.
- `duv_mem_arb_we_ip`, in, REQUESTERS: 1 = write, 0 = read.
- `duv_mem_arb_lock_ip`, in, REQUESTERS: request to keep ownership next cycle.
- `duv_mem_arb_addr_ip`, in, REQUESTERS*ADDR_W: packed addresses; requester k is slice k.
- `duv_mem_arb_wdata_ip`, in, REQUESTERS*DATA_W: packed write data.
- `duv_mem_arb_gnt_op`, out, REQUESTERS: one-hot or zero grant.
- `duv_mem_arb_rvalid_op`, out, REQUESTERS: read data valid for requester k.
- `duv_mem_arb_rdata_op`, out, DATA_W: read data, shared by all requesters.
- `duv_mem_arb_mem_en_op`, `_mem_we_op`, out, 1: memory enable and write enable.
- `duv_mem_arb_mem_addr_op`, out, ADDR_W: memory address.
- `duv_mem_arb_mem_wdata_op`, out, DATA_W: memory write data.
- `duv_mem_arb_mem_rdata_ip`, in, DATA_W: memory read data, valid one cycle after `mem_en && !mem_we`.

## Operation
- **Handshake**
  - A transfer occurs on an edge where `req[k] && gnt[k]`.
  - A requester holds req, we, addr and wdata stable until granted.
  - Grant is combinational from current requests and registered state.
- **Datapath**
  - `mem_en = |gnt`.
  - `mem_we`, `mem_addr` and `mem_wdata` are muxed from the winner.
  - When nothing is granted, they are 0.
- **State machine**
  - `ARB`:
    - Winner is the first asserted req searching upward from `ptr` with wrap-around.
    - On a transfer, `ptr <= winner+1 mod REQUESTERS`.
    - If the winner also has lock=1, go to `LOCKED`: owner := winner, `lock_cnt := 1`.
  - `LOCKED`:
    - Only the owner can be granted; others see gnt=0.
    - Each owner transfer with lock=1 increments `lock_cnt`.
    - The owner transfer with lock=0 returns to `ARB`.
    - The transfer at `lock_cnt == LOCK_MAX` returns to `ARB` regardless of lock.
    - If owner req=0 in `LOCKED`, ownership is released the same cycle: normal `ARB` selection applies combinationally for that cycle and state becomes `ARB`.
    - `ptr` is updated only on exit, to `owner+1`.
- **Read return**
  - On a read transfer by k, `rvalid[k]` is 1 in the next cycle.
  - `rdata_op` passes `mem_rdata_ip` through; it is meaningful only while some rvalid is high.
  - Writes have no response.
- **Reset values**
  - `ptr=0`, state `ARB`, `lock_cnt=0`, all rvalid 0.
  - While reset is high, gnt and mem_en are forced 0.

## Timing
- Read latency: grant edge → rvalid one cycle later. Write completes at the grant edge.
- Throughput: one transfer per cycle.
- Fairness bound: a continuously requesting requester waits at most `(REQUESTERS-1)*LOCK_MAX` cycles.
- Simultaneous read return and new grant to the same requester is legal; rvalid and gnt are independent.
- Reset during `LOCKED`:
  - Lock is dropped at that edge.
  - rvalid for a read granted in the reset cycle is suppressed.
  - After reset, requester 0 has highest priority.
- `lock_ip` from a non-owner, or while not granted, is ignored.
- A single requester alone is granted every cycle. Its `ptr` advances but has no effect.

## Structure
- Package `duv_mem_arb_pkg`:
  - state enum `{ARB, LOCKED}`.
  - default `ADDR_W`, `DATA_W` and `LOCK_MAX` constants.
  - `lock_cnt` width `$clog2(LOCK_MAX+1)`.
- Sub-module `duv_mem_arb_rr`: combinational round-robin picker. Input req vector and ptr; output one-hot grant and winner index.
- The top holds the FSM, `ptr`, `lock_cnt`, the payload mux and the registered rvalid.

## Test plan
- **Reset:** reset high 3 cycles with all req=1 → gnt=0, mem_en=0. First cycle after reset, gnt=0001.
- **Rotation:** all four req held for 8 cycles, lock=0 → gnt sequence 0001,0010,0100,1000,0001,…
- **Read return:**
  - Requester 2 writes 0xDEADBEEF to 0x3FF, then reads 0x3FF.
  - Expect rvalid=0100 one cycle after the read grant, with rdata=0xDEADBEEF.
- **Lock limit:**
  - Requester 1 holds req and lock for 20 cycles while requester 3 requests.
  - Expect 16 consecutive grants to 1, then a grant to 3.
- **Early release:**
  - Requester 0 locks, then drops req after 2 transfers while requester 2 requests.
  - Requester 2 is granted in the same cycle owner req falls.
- **Reset mid-lock:**
  - Reset asserted during lock with a read granted in the same cycle.
  - No rvalid follows, and `ptr` returns to 0.

Source files
------------

// File: rtl/duv_mem_arb_pkg.sv
// Shared types and default sizing for the DUV memory arbiter.
// The lock counter width is derived from the lock limit so it can hold LOCK_MAX.
package duv_mem_arb_pkg;

    typedef enum logic {
        ARB,
        LOCKED
    } arb_state_e;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_LOCK_MAX = 16;

    function automatic int lock_cnt_w(input int lock_max);
        return $clog2(lock_max + 1);
    endfunction

    localparam int DEF_LOCK_CNT_W = lock_cnt_w(DEF_LOCK_MAX);

endpackage

// File: rtl/duv_mem_arb_rr.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping around, returned both as a one-hot vector and as an index.
module duv_mem_arb_rr #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    always_comb begin
        int               idx;
        logic [IDX_W-1:0] idx_w;
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        idx_w  = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = IDX_W'(idx);
            if (!found && req[idx_w]) begin
                found       = 1'b1;
                winner      = idx_w;
                gnt[idx_w]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/duv_mem_arb.sv
// Round-robin arbiter sharing the single-port DUV memory between requesters,
// with a bounded lock that lets one requester keep the port for bursts.
//
//   state  | meaning
//   ARB    | round-robin selection from ptr on every cycle
//   LOCKED | only the owner may be granted; owner dropping req releases at once
module duv_mem_arb
    import duv_mem_arb_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LOCK_MAX   = DEF_LOCK_MAX
) (
    input  logic                         duv_mem_arb_clk_ip,
    input  logic                         duv_mem_arb_rst_ip,
    input  logic [REQUESTERS-1:0]        duv_mem_arb_req_ip,
    input  logic [REQUESTERS-1:0]        duv_mem_arb_we_ip,
    input  logic [REQUESTERS-1:0]        duv_mem_arb_lock_ip,
    input  logic [REQUESTERS*ADDR_W-1:0] duv_mem_arb_addr_ip,
    input  logic [REQUESTERS*DATA_W-1:0] duv_mem_arb_wdata_ip,
    output logic [REQUESTERS-1:0]        duv_mem_arb_gnt_op,
    output logic [REQUESTERS-1:0]        duv_mem_arb_rvalid_op,
    output logic [DATA_W-1:0]            duv_mem_arb_rdata_op,
    output logic                         duv_mem_arb_mem_en_op,
    output logic                         duv_mem_arb_mem_we_op,
    output logic [ADDR_W-1:0]            duv_mem_arb_mem_addr_op,
    output logic [DATA_W-1:0]            duv_mem_arb_mem_wdata_op,
    input  logic [DATA_W-1:0]            duv_mem_arb_mem_rdata_ip
);

    localparam int IDX_W = $clog2(REQUESTERS);
    localparam int CNT_W = lock_cnt_w(LOCK_MAX);

    arb_state_e        state, state_nx;
    logic [IDX_W-1:0]  ptr, ptr_nx;
    logic [IDX_W-1:0]  owner, owner_nx;
    logic [CNT_W-1:0]  lock_cnt, lock_cnt_nx;
    logic [REQUESTERS-1:0] rr_gnt;
    logic [IDX_W-1:0]  rr_winner;
    logic              rr_found;
    logic [REQUESTERS-1:0] gnt;
    logic [IDX_W-1:0]  winner;
    logic              owner_hold;
    logic              xfer;
    logic [REQUESTERS-1:0] rvalid;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == REQUESTERS - 1) ? '0 : i + 1'b1;
    endfunction

    duv_mem_arb_rr #(
        .N     (REQUESTERS),
        .IDX_W (IDX_W)
    ) u_rr (
        .req    (duv_mem_arb_req_ip),
        .ptr    (ptr),
        .gnt    (rr_gnt),
        .winner (rr_winner),
        .found  (rr_found)
    );

    always_ff @(posedge duv_mem_arb_clk_ip) begin
        if (duv_mem_arb_rst_ip) begin
            state    <= ARB;
            ptr      <= '0;
            owner    <= '0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            owner    <= owner_nx;
            lock_cnt <= lock_cnt_nx;
        end
    end

    // lock_cnt counts the owner's grants in the current run, including the one
    // that took the lock; the grant that brings the run to LOCK_MAX ends it.
    always_comb begin
        owner_hold  = (state == LOCKED) && duv_mem_arb_req_ip[owner];
        gnt         = '0;
        winner      = '0;
        state_nx    = state;
        ptr_nx      = ptr;
        owner_nx    = owner;
        lock_cnt_nx = lock_cnt;

        if (!duv_mem_arb_rst_ip) begin
            if (owner_hold) begin
                gnt[owner] = 1'b1;
                winner     = owner;
            end else if (rr_found) begin
                gnt    = rr_gnt;
                winner = rr_winner;
            end
        end
        xfer = |gnt;

        if (owner_hold) begin
            if (!duv_mem_arb_lock_ip[owner] || lock_cnt >= CNT_W'(LOCK_MAX - 1)) begin
                state_nx    = ARB;
                ptr_nx      = next_idx(owner);
                lock_cnt_nx = '0;
            end else begin
                lock_cnt_nx = lock_cnt + 1'b1;
            end
        end else begin
            state_nx    = ARB;
            lock_cnt_nx = '0;
            if (xfer) begin
                ptr_nx = next_idx(winner);
                if (duv_mem_arb_lock_ip[winner] && (LOCK_MAX > 1)) begin
                    state_nx    = LOCKED;
                    owner_nx    = winner;
                    lock_cnt_nx = CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        duv_mem_arb_mem_we_op    = 1'b0;
        duv_mem_arb_mem_addr_op  = '0;
        duv_mem_arb_mem_wdata_op = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            if (gnt[k]) begin
                duv_mem_arb_mem_we_op    = duv_mem_arb_mem_we_op | duv_mem_arb_we_ip[k];
                duv_mem_arb_mem_addr_op  = duv_mem_arb_mem_addr_op
                                         | duv_mem_arb_addr_ip[k*ADDR_W +: ADDR_W];
                duv_mem_arb_mem_wdata_op = duv_mem_arb_mem_wdata_op
                                         | duv_mem_arb_wdata_ip[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge duv_mem_arb_clk_ip) begin
        if (duv_mem_arb_rst_ip) begin
            rvalid <= '0;
        end else begin
            rvalid <= gnt & ~duv_mem_arb_we_ip;
        end
    end

    assign duv_mem_arb_gnt_op    = gnt;
    assign duv_mem_arb_mem_en_op = xfer;
    assign duv_mem_arb_rvalid_op = rvalid;
    assign duv_mem_arb_rdata_op  = duv_mem_arb_mem_rdata_ip;

endmodule

// File: tb/tb_duv_mem_arb.sv
// Directed bench for duv_mem_arb: a 1024x32 memory model with one-cycle read
// latency sits on the memory port; inputs change and outputs are sampled at negedge.
module tb_duv_mem_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [3:0]  lock;
    logic [9:0]  addr [4];
    logic [31:0] wdata [4];
    logic [39:0] addr_bus;
    logic [127:0] wdata_bus;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [31:0] rdata;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem [1024];

    int tests_run;
    int tests_failed;

    assign addr_bus  = {addr[3], addr[2], addr[1], addr[0]};
    assign wdata_bus = {wdata[3], wdata[2], wdata[1], wdata[0]};

    duv_mem_arb dut (
        .duv_mem_arb_clk_ip       (clk),
        .duv_mem_arb_rst_ip       (rst),
        .duv_mem_arb_req_ip       (req),
        .duv_mem_arb_we_ip        (we),
        .duv_mem_arb_lock_ip      (lock),
        .duv_mem_arb_addr_ip      (addr_bus),
        .duv_mem_arb_wdata_ip     (wdata_bus),
        .duv_mem_arb_gnt_op       (gnt),
        .duv_mem_arb_rvalid_op    (rvalid),
        .duv_mem_arb_rdata_op     (rdata),
        .duv_mem_arb_mem_en_op    (mem_en),
        .duv_mem_arb_mem_we_op    (mem_we),
        .duv_mem_arb_mem_addr_op  (mem_addr),
        .duv_mem_arb_mem_wdata_op (mem_wdata),
        .duv_mem_arb_mem_rdata_ip (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    task automatic clear_inputs();
        req  = '0;
        we   = '0;
        lock = '0;
        for (int k = 0; k < 4; k++) begin
            addr[k]  = '0;
            wdata[k] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++;
            if (gnt !== 4'b0000) begin
                tests_failed++;
                $display("FAIL reset_gnt cycle %0d: got %b expected 0000", c, gnt);
            end
            tests_run++;
            if (mem_en !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_mem_en cycle %0d: got %b expected 0", c, mem_en);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (gnt !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_first_gnt: got %b expected 0001", gnt);
        end
        tests_run++;
        if (rvalid !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_rvalid: got %b expected 0000", rvalid);
        end
        @(negedge clk);
    endtask

    task automatic test_rotation();
        logic [3:0] exp_gnt [8];
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                    4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 4; k++) addr[k] = 10'(16 * k + 5);
        for (int c = 0; c < 8; c++) begin
            #1;
            tests_run++;
            if (gnt !== exp_gnt[c]) begin
                tests_failed++;
                $display("FAIL rotation_gnt cycle %0d: got %b expected %b", c, gnt, exp_gnt[c]);
            end
            tests_run++;
            if (mem_addr !== 10'(16 * (c % 4) + 5)) begin
                tests_failed++;
                $display("FAIL rotation_addr cycle %0d: got %h expected %h",
                         c, mem_addr, 10'(16 * (c % 4) + 5));
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_read_return();
        do_reset();
        req      = 4'b0100;
        we       = 4'b0100;
        addr[2]  = 10'h3FF;
        wdata[2] = 32'hDEADBEEF;
        #1;
        tests_run++;
        if (gnt !== 4'b0100 || mem_en !== 1'b1 || mem_we !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_grant: got gnt=%b en=%b we=%b expected gnt=0100 en=1 we=1",
                     gnt, mem_en, mem_we);
        end
        tests_run++;
        if (mem_addr !== 10'h3FF || mem_wdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL write_payload: got addr=%h data=%h expected addr=3ff data=deadbeef",
                     mem_addr, mem_wdata);
        end
        @(negedge clk);
        we = 4'b0000;
        #1;
        tests_run++;
        if (rvalid !== 4'b0000) begin
            tests_failed++;
            $display("FAIL write_no_rvalid: got %b expected 0000", rvalid);
        end
        tests_run++;
        if (gnt !== 4'b0100 || mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_grant: got gnt=%b we=%b expected gnt=0100 we=0", gnt, mem_we);
        end
        @(negedge clk);
        req = 4'b0000;
        #1;
        tests_run++;
        if (rvalid !== 4'b0100) begin
            tests_failed++;
            $display("FAIL read_rvalid: got %b expected 0100", rvalid);
        end
        tests_run++;
        if (rdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL read_rdata: got %h expected deadbeef", rdata);
        end
        tests_run++;
        if (gnt !== 4'b0000 || mem_en !== 1'b0 || mem_addr !== 10'h000) begin
            tests_failed++;
            $display("FAIL idle_outputs: got gnt=%b en=%b addr=%h expected 0000 0 000",
                     gnt, mem_en, mem_addr);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (rvalid !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rvalid_single_cycle: got %b expected 0000", rvalid);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_lock_limit();
        logic [3:0] exp;
        do_reset();
        req  = 4'b1010;
        lock = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            exp = (c < 16) ? 4'b0010 : ((c == 16) ? 4'b1000 : 4'b0010);
            #1;
            tests_run++;
            if (gnt !== exp) begin
                tests_failed++;
                $display("FAIL lock_limit_gnt cycle %0d: got %b expected %b", c, gnt, exp);
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_early_release();
        logic [3:0] exp_gnt [4];
        logic [3:0] req_seq [4];
        exp_gnt = '{4'b0001, 4'b0001, 4'b0100, 4'b0001};
        req_seq = '{4'b0101, 4'b0101, 4'b0100, 4'b0101};
        do_reset();
        addr[2] = 10'h2A5;
        for (int c = 0; c < 4; c++) begin
            req  = req_seq[c];
            lock = (c < 2) ? 4'b0001 : 4'b0000;
            #1;
            tests_run++;
            if (gnt !== exp_gnt[c]) begin
                tests_failed++;
                $display("FAIL early_release_gnt cycle %0d: got %b expected %b", c, gnt, exp_gnt[c]);
            end
            if (c == 2) begin
                tests_run++;
                if (mem_addr !== 10'h2A5) begin
                    tests_failed++;
                    $display("FAIL early_release_addr: got %h expected 2a5", mem_addr);
                end
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        req     = 4'b1010;
        lock    = 4'b0010;
        addr[1] = 10'h3FF;
        #1;
        tests_run++;
        if (gnt !== 4'b0010) begin
            tests_failed++;
            $display("FAIL midlock_take: got %b expected 0010", gnt);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (gnt !== 4'b0010) begin
            tests_failed++;
            $display("FAIL midlock_hold: got %b expected 0010", gnt);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (gnt !== 4'b0000 || mem_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL midlock_reset_gnt: got gnt=%b en=%b expected 0000 0", gnt, mem_en);
        end
        tests_run++;
        if (rvalid !== 4'b0010) begin
            tests_failed++;
            $display("FAIL midlock_prior_rvalid: got %b expected 0010", rvalid);
        end
        @(negedge clk);
        rst  = 1'b0;
        req  = 4'b1011;
        lock = 4'b0000;
        #1;
        tests_run++;
        if (rvalid !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midlock_rvalid_suppressed: got %b expected 0000", rvalid);
        end
        tests_run++;
        if (gnt !== 4'b0001) begin
            tests_failed++;
            $display("FAIL midlock_ptr_zero: got %b expected 0001", gnt);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        mem_rdata    = '0;
        clear_inputs();
        test_reset();
        test_rotation();
        test_read_return();
        test_lock_limit();
        test_early_release();
        test_reset_mid_lock();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
